seq_shift_unit: RTL and testbench

Parametrised, multi-cycle shift/rotate unit. It is the next generation of the ALU's small combinational shifter. Operands are WIDTH bits wide, shift amounts cover the full operand width, and four modes are supported: LSL, LSR, ASR and ROR. The unit shifts one bit per clock under a valid/ready handshake on both sides, and also produces carry and zero flags for the ALU flag logic.

---
 rtl/seq_shift_unit.sv | 111 +++++++++++
 tb/tb_seq_shift_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit of shift per clock, valid/ready on both sides.
// Modes: LSL, LSR, ASR, ROR. It also produces carry and zero flags for the ALU flag logic.
module seq_shift_unit #(
  parameter int WIDTH = 8,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AW-1:0]    amount,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  state_t           state, state_next;
  logic [WIDTH-1:0] work, work_next;
  logic [AW-1:0]    count, count_next;
  logic [1:0]       mode_reg, mode_reg_next;
  logic             carry_reg, carry_reg_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      mode_reg  <= '0;
      carry_reg <= 1'b0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      count     <= count_next;
      mode_reg  <= mode_reg_next;
      carry_reg <= carry_reg_next;
    end
  end

  always_comb begin
    state_next     = state;
    work_next      = work;
    count_next     = count;
    mode_reg_next  = mode_reg;
    carry_reg_next = carry_reg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_next      = a;
          mode_reg_next  = mode;
          count_next     = amount;
          carry_reg_next = 1'b0;
          state_next     = (amount == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        case (mode_reg)
          MODE_LSL: begin
            carry_reg_next = work[WIDTH-1];
            work_next      = {work[WIDTH-2:0], 1'b0};
          end
          MODE_LSR: begin
            carry_reg_next = work[0];
            work_next      = {1'b0, work[WIDTH-1:1]};
          end
          MODE_ASR: begin
            carry_reg_next = work[0];
            work_next      = {work[WIDTH-1], work[WIDTH-1:1]};
          end
          MODE_ROR: begin
            carry_reg_next = work[0];
            work_next      = {work[0], work[WIDTH-1:1]};
          end
          default: ;
        endcase
        count_next = count - AW'(1);
        // count is at least 1 here; the step taking it to 0 is the last one
        if (count == AW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = work;
  assign carry     = carry_reg;
  assign zero      = (work == '0);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed vectors, randomized commands against
// an arithmetic reference model, back-pressure, back-to-back traffic and mid-BUSY abort.
module tb_seq_shift_unit;
  localparam int W  = 8;
  localparam int AW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [AW-1:0] amount = '0;
  logic [1:0]    mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          carry;
  logic          zero;

  int checks = 0;
  int errors = 0;

  seq_shift_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .amount(amount), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: the whole shift done at once with ordinary operators.
  function automatic logic [W:0] model(input logic [W-1:0] av, input int n, input logic [1:0] md);
    logic [W-1:0] r;
    logic c;
    r = av;
    c = 1'b0;
    case (md)
      2'b00: begin r = av << n; if (n > 0) c = av[W-n]; end
      2'b01: begin r = av >> n; if (n > 0) c = av[n-1]; end
      2'b10: begin r = $signed(av) >>> n; if (n > 0) c = av[n-1]; end
      default: begin r = (av >> n) | (av << (W - n)); if (n > 0) c = r[W-1]; end
    endcase
    return {c, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command, check latency and outputs, optionally hold out_ready low, then hand off.
  task automatic run_cmd(input logic [W-1:0] av, input int n, input logic [1:0] md, input int hold);
    logic [W:0] exp;
    logic [W-1:0] exp_r;
    logic exp_c, exp_z;
    int lat;
    exp   = model(av, n, md);
    exp_r = exp[W-1:0];
    exp_c = exp[W];
    exp_z = (exp_r == '0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_before_cmd: got %b want 1", in_ready);
    end
    a = av; amount = AW'(n); mode = md; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat <= 4 * W) begin
      // noise on the inputs while BUSY must not be sampled
      in_valid = 1'($urandom); a = W'($urandom); amount = AW'($urandom); mode = 2'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat != n + 1) begin
      errors++;
      $display("FAIL latency: got %0d want %0d (a=%h n=%0d mode=%0d)", lat, n + 1, av, n, md);
    end
    checks++;
    if (result !== exp_r || carry !== exp_c || zero !== exp_z) begin
      errors++;
      $display("FAIL result: got r=%h c=%b z=%b want r=%h c=%b z=%b (a=%h n=%0d mode=%0d)",
               result, carry, zero, exp_r, exp_c, exp_z, av, n, md);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = W'($urandom); amount = AW'($urandom); mode = 2'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_r ||
          carry !== exp_c || zero !== exp_z) begin
        errors++;
        $display("FAIL hold: got ov=%b ir=%b r=%h c=%b z=%b want ov=1 ir=0 r=%h c=%b z=%b",
                 out_valid, in_ready, result, carry, zero, exp_r, exp_c, exp_z);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    $display("cmd a=%h n=%0d mode=%0d hold=%0d -> r=%h c=%b z=%b lat=%0d",
             av, n, md, hold, exp_r, exp_c, exp_z, lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: got ir=%b ov=%b r=%h z=%b c=%b want 1 0 00 1 0",
               in_ready, out_valid, result, zero, carry);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    // get into BUSY, then reset asynchronously mid-cycle
    a = 8'hF3; amount = 3'd5; mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got ir=%b ov=%b r=%h z=%b c=%b want 1 0 00 1 0",
               in_ready, out_valid, result, zero, carry);
    end
    #3 rst_n = 1'b1;
    tick();
    $display("reset checks done");
  endtask

  task automatic test_directed;
    run_cmd(8'b1001_0110, 3, 2'b00, 0);
    run_cmd(8'b1000_0110, 2, 2'b10, 0);
    run_cmd(8'b0000_0011, 1, 2'b11, 0);
    run_cmd(8'h01, 1, 2'b01, 0);
    for (int m = 0; m < 4; m++) run_cmd(8'h5A, 0, 2'(m), 0);
    run_cmd(8'hFF, 7, 2'b00, 0);
  endtask

  task automatic test_back_pressure;
    run_cmd(8'hC5, 4, 2'b10, 5);
    run_cmd(8'h3C, 2, 2'b11, 0);
  endtask

  task automatic test_abort;
    int seen;
    a = 8'hE7; amount = 3'd6; mode = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d out_valid cycles want 0", seen);
    end
    $display("abort: aborted LSR n=6, out_valid cycles after abort=%0d", seen);
    run_cmd(8'h01, 2, 2'b00, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_cmd(W'($urandom), int'($urandom_range(0, W - 1)), 2'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      run_cmd(W'($urandom), i % W, 2'(i), 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
